// File: rtl/dag_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : dag_host_loader
// Description : Host-side command engine for the DAG processor core.
//               One valid/ready word stream carries header beats and payload.
//               The engine packs instruction beats into wide instructions and
//               streams data words into the banked data memory. It reads data
//               back through a response FIFO, runs the core until its program
//               counter reaches a target, then swaps the ping/pong buffers.
// Ports       : clk_i / rst_ni              clock, async active-low reset
//               in_valid_i/in_ready_o/in_data_i     command + payload stream
//               rsp_valid_o/rsp_ready_i/rsp_data_o  readback stream
//               busy_o, done_o, err_o        status (done/err are 1-cycle)
//               enable_execution_o, io_ping_wr_o    core run control
//               current_instr_rd_addr_i      core program counter
//               init_instr_*                 instruction memory write port
//               init_data_*                  data memory read/write port
// Revision    : 1.0 - initial release
// ============================================================================
module dag_host_loader #(
   parameter int HOST_W          = 32,
   parameter int INSTR_L         = 96,
   parameter int INSTR_ADDR_L    = 10,
   parameter int WORD_L          = 32,
   parameter int N_BANKS         = 8,
   parameter int DATA_MEM_ADDR_L = 9,
   parameter int RD_LAT          = 1,
   parameter int RSP_DEPTH       = 4
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        in_valid_i,
   output logic                                        in_ready_o,
   input  logic [HOST_W-1:0]                           in_data_i,
   output logic                                        rsp_valid_o,
   input  logic                                        rsp_ready_i,
   output logic [WORD_L-1:0]                           rsp_data_o,
   output logic                                        busy_o,
   output logic                                        done_o,
   output logic                                        err_o,
   output logic                                        enable_execution_o,
   output logic                                        io_ping_wr_o,
   input  logic [INSTR_ADDR_L-1:0]                     current_instr_rd_addr_i,
   output logic [INSTR_L-1:0]                          init_instr_o,
   output logic [INSTR_ADDR_L-1:0]                     init_instr_addr_o,
   output logic                                        init_instr_we_o,
   output logic [WORD_L-1:0]                           init_data_in_o,
   input  logic [WORD_L-1:0]                           init_data_out_i,
   output logic [$clog2(N_BANKS)+DATA_MEM_ADDR_L-1:0]  init_data_addr_o,
   output logic                                        init_data_we_o,
   output logic                                        init_data_re_o
);

   localparam int DADDR_L = $clog2(N_BANKS) + DATA_MEM_ADDR_L;
   localparam int BEATS   = (INSTR_L + HOST_W - 1) / HOST_W;
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W   = $clog2(RSP_DEPTH + 1);

   localparam logic [3:0] OP_WR_INSTR = 4'd1;
   localparam logic [3:0] OP_WR_DATA  = 4'd2;
   localparam logic [3:0] OP_RD_DATA  = 4'd3;
   localparam logic [3:0] OP_RUN      = 4'd4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WINSTR = 3'd1,
      S_WDATA  = 3'd2,
      S_RDATA  = 3'd3,
      S_RUN    = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   done_d, err_d;

   logic [11:0]             len_q, item_q, issued_q;
   logic [BEAT_W-1:0]       beat_q;
   logic [INSTR_ADDR_L-1:0] iaddr_q, instr_addr_q, run_pc_q;
   logic [DADDR_L-1:0]      daddr_q, wr_daddr_q;
   logic [WORD_L-1:0]       data_in_q;
   logic                    instr_we_q, data_we_q, done_q, err_q, ping_q;
   logic [RD_LAT-1:0]       rd_pipe_q;
   logic [CNT_W-1:0]        inflight_q, fifo_cnt_q;
   logic [WORD_L-1:0]       fifo_q [RSP_DEPTH];
   logic [PTR_W-1:0]        wptr_q, rptr_q;

   logic [3:0]  w_op;
   logic [11:0] w_len;
   logic        w_ifire, w_dfire, w_last_beat, w_last_item;
   logic        w_re, w_push, w_pop, w_run_end;

   assign w_op        = in_data_i[31:28];
   assign w_len       = in_data_i[27:16];
   assign w_ifire     = (state_q == S_WINSTR) && in_valid_i;
   assign w_dfire     = (state_q == S_WDATA) && in_valid_i;
   assign w_last_beat = (beat_q == BEAT_W'(BEATS - 1));
   // item_q counts instructions (WINSTR), words (WDATA) or pops (RDATA)
   assign w_last_item = (item_q == len_q - 12'd1);
   assign w_pop       = rsp_valid_o && rsp_ready_i;
   assign w_push      = rd_pipe_q[RD_LAT-1];
   assign w_run_end   = (state_q == S_RUN) && (current_instr_rd_addr_i == run_pc_q);
   // Reads in flight are counted against FIFO space so every returning word
   // always has a slot, regardless of how long the host stalls.
   assign w_re        = (state_q == S_RDATA) && (issued_q != len_q) &&
                        (({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (CNT_W+1)'(RSP_DEPTH));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               case (w_op)
                  OP_WR_INSTR: if (w_len == 12'd0) done_d = 1'b1; else state_d = S_WINSTR;
                  OP_WR_DATA:  if (w_len == 12'd0) done_d = 1'b1; else state_d = S_WDATA;
                  OP_RD_DATA:  if (w_len == 12'd0) done_d = 1'b1; else state_d = S_RDATA;
                  OP_RUN:      state_d = S_RUN;
                  default:     err_d = 1'b1;
               endcase
            end
         end
         S_WINSTR: if (w_ifire && w_last_beat && w_last_item) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         S_WDATA: if (w_dfire && w_last_item) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         S_RDATA: if (w_pop && w_last_item) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         S_RUN: if (w_run_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_q        <= '0;
         item_q       <= '0;
         issued_q     <= '0;
         beat_q       <= '0;
         iaddr_q      <= '0;
         instr_addr_q <= '0;
         run_pc_q     <= '0;
         daddr_q      <= '0;
         wr_daddr_q   <= '0;
         data_in_q    <= '0;
         instr_we_q   <= 1'b0;
         data_we_q    <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         ping_q       <= 1'b0;
      end else begin
         done_q     <= done_d;
         err_q      <= err_d;
         instr_we_q <= w_ifire && w_last_beat;
         data_we_q  <= w_dfire;
         if ((state_q == S_IDLE) && in_valid_i) begin
            len_q    <= w_len;
            item_q   <= '0;
            issued_q <= '0;
            beat_q   <= '0;
            iaddr_q  <= in_data_i[INSTR_ADDR_L-1:0];
            run_pc_q <= in_data_i[INSTR_ADDR_L-1:0];
            daddr_q  <= in_data_i[DADDR_L-1:0];
         end
         if (w_ifire) begin
            if (w_last_beat) begin
               beat_q       <= '0;
               item_q       <= item_q + 12'd1;
               instr_addr_q <= iaddr_q;
               iaddr_q      <= iaddr_q + INSTR_ADDR_L'(1);
            end else begin
               beat_q <= beat_q + BEAT_W'(1);
            end
         end
         if (w_dfire) begin
            data_in_q  <= in_data_i[WORD_L-1:0];
            wr_daddr_q <= daddr_q;
            daddr_q    <= daddr_q + DADDR_L'(1);
            item_q     <= item_q + 12'd1;
         end
         if (w_re) begin
            daddr_q  <= daddr_q + DADDR_L'(1);
            issued_q <= issued_q + 12'd1;
         end
         if ((state_q == S_RDATA) && w_pop) item_q <= item_q + 12'd1;
         if (w_run_end) ping_q <= ~ping_q;
      end
   end

   // One register per beat; the last beat keeps only the bits that fit.
   // The assembled word stays put during the write cycle because the next
   // instruction's first beat lands only at the end of that cycle.
   for (genvar k = 0; k < BEATS; k++) begin : g_instr_seg
      localparam int LO = k * HOST_W;
      localparam int SW = ((INSTR_L - LO) < HOST_W) ? (INSTR_L - LO) : HOST_W;
      logic [SW-1:0] seg_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)                                  seg_q <= '0;
         else if (w_ifire && (beat_q == BEAT_W'(k)))   seg_q <= in_data_i[SW-1:0];
      end
      assign init_instr_o[LO +: SW] = seg_q;
   end

   // Read-return pipeline, in-flight counter and response FIFO
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_pipe_q  <= '0;
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         rd_pipe_q <= RD_LAT'({rd_pipe_q, w_re});
         case ({w_re, w_push})
            2'b10:   inflight_q <= inflight_q + CNT_W'(1);
            2'b01:   inflight_q <= inflight_q - CNT_W'(1);
            default: inflight_q <= inflight_q;
         endcase
         case ({w_push, w_pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
         if (w_push) begin
            fifo_q[wptr_q] <= init_data_out_i;
            wptr_q <= (wptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rptr_q <= (rptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
         end
      end
   end

   assign in_ready_o         = (state_q == S_IDLE) || (state_q == S_WINSTR) || (state_q == S_WDATA);
   assign busy_o             = (state_q != S_IDLE);
   assign done_o             = done_q;
   assign err_o              = err_q;
   assign enable_execution_o = (state_q == S_RUN);
   assign io_ping_wr_o       = ping_q;
   assign init_instr_addr_o  = instr_addr_q;
   assign init_instr_we_o    = instr_we_q;
   assign init_data_in_o     = data_in_q;
   assign init_data_we_o     = data_we_q;
   assign init_data_re_o     = w_re;
   assign init_data_addr_o   = (state_q == S_RDATA) ? daddr_q : wr_daddr_q;
   assign rsp_valid_o        = (fifo_cnt_q != '0);
   assign rsp_data_o         = fifo_q[rptr_q];

endmodule
`default_nettype wire

// File: tb/tb_dag_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dag_host_loader
// Description : Self-checking bench for dag_host_loader with a core memory
//               model, header decode vector table, directed corner sequences
//               and randomized load/readback traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dag_host_loader;
   localparam int RSP_DEPTH = 4;

   typedef struct packed { logic [11:0] a; logic [95:0] d; } wr_t;
   typedef struct packed { logic [31:0] hdr; logic exp_err; logic exp_done; } hv_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, rsp_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic in_ready, rsp_valid, busy_o, done_o, err_o, en_o, ping_o;
   logic [31:0] rsp_data, init_data_in;
   logic [95:0] init_instr;
   logic [9:0]  init_instr_addr;
   logic [11:0] init_data_addr;
   logic        init_instr_we, init_data_we, init_data_re;
   logic [31:0] init_data_out = '0;
   logic [9:0]  pc = '0;
   logic [31:0] dmem [4096] = '{default: '0};
   logic [31:0] exp_dmem [4096] = '{default: '0};

   wr_t iw_q[$], dw_q[$];
   logic [31:0] rsp_q[$];
   int rd_issued = 0, rd_popped = 0, max_out = 0;
   int done_cnt = 0, err_cnt = 0, overlap = 0, en_cnt = 0;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   dag_host_loader dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .enable_execution_o(en_o), .io_ping_wr_o(ping_o),
      .current_instr_rd_addr_i(pc),
      .init_instr_o(init_instr), .init_instr_addr_o(init_instr_addr), .init_instr_we_o(init_instr_we),
      .init_data_in_o(init_data_in), .init_data_out_i(init_data_out), .init_data_addr_o(init_data_addr),
      .init_data_we_o(init_data_we), .init_data_re_o(init_data_re)
   );

   // Core model: data memory with one-cycle read latency, PC advancing while enabled
   always @(posedge clk) begin
      if (init_data_we) dmem[init_data_addr] <= init_data_in;
      if (init_data_re) init_data_out <= dmem[init_data_addr];
      if (en_o) pc <= pc + 10'd1;
   end

   // Event monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (init_instr_we) iw_q.push_back({2'b00, init_instr_addr, init_instr});
      if (init_data_we)  dw_q.push_back({init_data_addr, 64'd0, init_data_in});
      if (rsp_valid && rsp_ready) begin
         rsp_q.push_back(rsp_data);
         rd_popped = rd_popped + 1;
      end
      if (init_data_re) rd_issued = rd_issued + 1;
      if (rd_issued - rd_popped > max_out) max_out = rd_issued - rd_popped;
      if (done_o) done_cnt = done_cnt + 1;
      if (err_o) err_cnt = err_cnt + 1;
      if (done_o && err_o) overlap = overlap + 1;
      if (en_o) en_cnt = en_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge
   task automatic send(input logic [31:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 200) begin tick(); n++; end
      if (!in_ready) begin
         errors = errors + 1;
         checks = checks + 1;
         $display("FAIL send_timeout: in_ready stayed 0 for beat %0h", d);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_wr_data(input logic [15:0] base, input int len);
      int s;
      logic [31:0] w [$];
      s = dw_q.size();
      send({4'h2, 12'(len), base});
      for (int i = 0; i < len; i++) begin
         w.push_back($urandom);
         exp_dmem[12'(base + 16'(i))] = w[i];
         send(w[i]);
      end
      chk("wr_data_done", done_o, 1'b1);
      tick();
      chk("wr_data_count", 128'(dw_q.size() - s), 128'(len));
      for (int i = 0; i < len && i < dw_q.size() - s; i++)
         chk($sformatf("wr_data[%0d]", i), dw_q[s+i], {12'(base + 16'(i)), 64'd0, w[i]});
   endtask

   task automatic do_wr_instr(input logic [9:0] base, input int len);
      int s;
      logic [31:0] b0, b1, b2;
      logic [95:0] ei [$];
      s = iw_q.size();
      send({4'h1, 12'(len), 6'd0, base});
      for (int i = 0; i < len; i++) begin
         b0 = $urandom; b1 = $urandom; b2 = $urandom;
         send(b0); send(b1); send(b2);
         ei.push_back({b2, b1, b0});
      end
      chk("wr_instr_done", done_o, 1'b1);
      tick();
      chk("wr_instr_count", 128'(iw_q.size() - s), 128'(len));
      for (int i = 0; i < len && i < iw_q.size() - s; i++)
         chk($sformatf("wr_instr[%0d]", i), iw_q[s+i], {2'b00, 10'(base + 10'(i)), ei[i]});
   endtask

   task automatic do_rd_data(input logic [15:0] base, input int len, input bit stall);
      int s, si, sd, n;
      s = rsp_q.size(); si = rd_issued; sd = done_cnt;
      if (stall) rsp_ready = 1'b0;
      send({4'h3, 12'(len), base});
      if (stall) begin
         repeat (20) tick();
         chk("rd_stall_issued_le_depth", 128'((rd_issued - si) <= RSP_DEPTH), 1);
         chk("rd_stall_rsp_valid", rsp_valid, 1'b1);
         chk("rd_stall_no_done", 128'(done_cnt - sd), 0);
      end
      n = 0;
      while (!done_o && n < 400) begin
         rsp_ready = stall ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      rsp_ready = 1'b0;
      chk("rd_done", done_o, 1'b1);
      chk("rd_count", 128'(rsp_q.size() - s), 128'(len));
      for (int i = 0; i < len && i < rsp_q.size() - s; i++)
         chk($sformatf("rd_word[%0d]", i), rsp_q[s+i], exp_dmem[12'(base + 16'(i))]);
   endtask

   hv_t vec [8];
   logic [31:0] bts [6];
   int s_iw, s_dw, s_rd, sd, se, n;
   logic [9:0] pc0, base10;

   initial begin
      vec[0] = '{hdr: 32'h0000_1234, exp_err: 1'b1, exp_done: 1'b0};
      vec[1] = '{hdr: 32'h5001_0000, exp_err: 1'b1, exp_done: 1'b0};
      vec[2] = '{hdr: 32'hF000_0000, exp_err: 1'b1, exp_done: 1'b0};
      vec[3] = '{hdr: 32'h1000_0123, exp_err: 1'b0, exp_done: 1'b1};
      vec[4] = '{hdr: 32'h7FFF_FFFF, exp_err: 1'b1, exp_done: 1'b0};
      vec[5] = '{hdr: 32'h2000_0FFF, exp_err: 1'b0, exp_done: 1'b1};
      vec[6] = '{hdr: 32'h3000_0001, exp_err: 1'b0, exp_done: 1'b1};
      vec[7] = '{hdr: 32'h8123_4567, exp_err: 1'b1, exp_done: 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {rsp_valid, busy_o, done_o, err_o, en_o, ping_o, init_instr_we,
                            init_data_we, init_data_re, init_instr_addr, init_data_addr,
                            init_data_in, rsp_data}, '0);
      chk("reset_instr", init_instr, '0);
      rst_n = 1'b1;
      tick();
      chk("reset_in_ready", in_ready, 1'b1);

      // Header decode table: illegal ops and zero-length loads
      for (int i = 0; i < 8; i++) begin
         s_iw = iw_q.size(); s_dw = dw_q.size(); s_rd = rd_issued;
         send(vec[i].hdr);
         chk($sformatf("hdr%0d_err", i), err_o, vec[i].exp_err);
         chk($sformatf("hdr%0d_done", i), done_o, vec[i].exp_done);
         chk($sformatf("hdr%0d_busy", i), busy_o, 1'b0);
         tick();
         chk($sformatf("hdr%0d_pulse", i), {err_o, done_o}, 2'b00);
         chk($sformatf("hdr%0d_nostrobe", i), 128'((iw_q.size() - s_iw) + (dw_q.size() - s_dw) + (rd_issued - s_rd)), 0);
      end

      // Two instructions at 0x3FE with address wrap
      s_iw = iw_q.size();
      send(32'h1002_03FE);
      for (int k = 0; k < 6; k++) begin
         bts[k] = $urandom;
         send(bts[k]);
         if (k == 2) chk("winstr_we_first", init_instr_we, 1'b1);
         if (k == 3) chk("winstr_we_one_cycle", init_instr_we, 1'b0);
      end
      chk("winstr_we_last", init_instr_we, 1'b1);
      chk("winstr_done", done_o, 1'b1);
      chk("winstr_busy_off", busy_o, 1'b0);
      tick();
      chk("winstr_count", 128'(iw_q.size() - s_iw), 2);
      chk("winstr_i0", iw_q[s_iw], {12'h3FE, bts[2], bts[1], bts[0]});
      chk("winstr_i1", iw_q[s_iw+1], {12'h3FF, bts[5], bts[4], bts[3]});

      // Data write wrapping 0xFFF -> 0x000
      s_dw = dw_q.size(); sd = done_cnt;
      send(32'h2003_0FFF);
      send(32'hAAAA_0001); send(32'hBBBB_0002); send(32'hCCCC_0003);
      exp_dmem[12'hFFF] = 32'hAAAA_0001;
      exp_dmem[12'h000] = 32'hBBBB_0002;
      exp_dmem[12'h001] = 32'hCCCC_0003;
      chk("wdata_done", done_o, 1'b1);
      tick(); tick();
      chk("wdata_done_once", 128'(done_cnt - sd), 1);
      chk("wdata_count", 128'(dw_q.size() - s_dw), 3);
      chk("wdata_w0", dw_q[s_dw],   {12'hFFF, 64'd0, 32'hAAAA_0001});
      chk("wdata_w1", dw_q[s_dw+1], {12'h000, 64'd0, 32'hBBBB_0002});
      chk("wdata_w2", dw_q[s_dw+2], {12'h001, 64'd0, 32'hCCCC_0003});

      // Readback under host backpressure
      do_wr_data(16'h0100, 6);
      do_rd_data(16'h0100, 6, 1'b1);
      do_rd_data(16'h0FFE, 3, 1'b0);

      // Randomized loads and readbacks against the memory model
      for (int r = 0; r < 20; r++) begin
         case ($urandom_range(0, 2))
            0:       do_wr_data(16'($urandom), int'($urandom_range(1, 6)));
            1:       do_rd_data(16'($urandom), int'($urandom_range(1, 8)), 1'b0);
            default: do_wr_instr(10'($urandom), int'($urandom_range(1, 3)));
         endcase
      end
      chk("loads_keep_ping", ping_o, 1'b0);

      // RUN to PC 0x010, then RUN with base equal to the current PC
      se = en_cnt; pc0 = pc;
      send(32'h4000_0010);
      n = 0;
      while (!done_o && n < 2000) begin tick(); n++; end
      chk("run1_done", done_o, 1'b1);
      chk("run1_enable_off", en_o, 1'b0);
      chk("run1_enable_cycles", 128'(en_cnt - se), 128'(int'(10'(10'h010 - pc0)) + 1));
      chk("run1_ping", ping_o, 1'b1);
      tick();
      se = en_cnt; base10 = pc;
      send({16'h4000, 6'd0, base10});
      n = 0;
      while (!done_o && n < 2000) begin tick(); n++; end
      chk("run2_done", done_o, 1'b1);
      chk("run2_enable_cycles", 128'(en_cnt - se), 1);
      chk("run2_ping", ping_o, 1'b0);
      tick();

      // Reset in the middle of an instruction
      s_iw = iw_q.size();
      send(32'h1001_0005);
      send(32'h1234_5678);
      send(32'h9ABC_DEF0);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy_o, 1'b0);
      tick();
      rst_n = 1'b1;
      chk("midrst_ready", in_ready, 1'b1);
      do_wr_data(16'h0200, 2);
      repeat (3) tick();
      chk("midrst_no_instr_we", 128'(iw_q.size() - s_iw), 0);

      chk("done_err_disjoint", 128'(overlap), 0);
      chk("fifo_never_overfilled", 128'(max_out <= RSP_DEPTH), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
